// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM encodings, sizing constants and the saturating counter helper for mem_arbiter
package mem_arb_pkg;
    localparam int REQ_N = 2;
    localparam int CNT_W = 16;
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, CAPTURE = 2'd3;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side handshake bundle for both mem_arbiter clients
interface mem_arbiter_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic              req0, we0, gnt0, rvalid0;
    logic [AWIDTH-1:0] addr0;
    logic [DWIDTH-1:0] wdata0, rdata0;
    logic              req1, we1, gnt1, rvalid1;
    logic [AWIDTH-1:0] addr1;
    logic [DWIDTH-1:0] wdata1, rdata1;
    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
    );
    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; ptr names the last granted requester, which loses a tie
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic             ptr,
    output logic [REQ_N-1:0] gnt
);
    assign gnt[0] = req[0] & (!req[1] | ptr);
    assign gnt[1] = req[1] & (!req[0] | !ptr);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port memory by two requesters; MEM_ARB_STATS_EN adds gnt_cnt0/gnt_cnt1
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`endif
);
    logic [1:0]        state;
    logic [REQ_N-1:0]  req, win, gnt_q, rvalid_q;
    logic              ptr, owner, we_sel;
    logic [AWIDTH-1:0] addr_sel;
    logic [DWIDTH-1:0] wdata_sel, wdata_q;
    logic [DWIDTH-1:0] rdata_q [REQ_N];

    assign req       = {bus.req1, bus.req0};
    assign we_sel    = win[1] ? bus.we1 : bus.we0;
    assign addr_sel  = win[1] ? bus.addr1 : bus.addr0;
    assign wdata_sel = win[1] ? bus.wdata1 : bus.wdata0;

    rr_arb2 u_arb (.req(req), .ptr(ptr), .gnt(win));

    // the write strobe doubles as the bus enable, so reset releases the bus immediately
    assign mem_data = mem_wr ? wdata_q : 'z;

    assign bus.gnt0    = gnt_q[0];
    assign bus.gnt1    = gnt_q[1];
    assign bus.rvalid0 = rvalid_q[0];
    assign bus.rvalid1 = rvalid_q[1];
    assign bus.rdata0  = rdata_q[0];
    assign bus.rdata1  = rdata_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            rvalid_q <= '0;
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            wdata_q  <= '0;
            owner    <= 1'b0;
            ptr      <= 1'b1;
            rdata_q  <= '{default: '0};
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            mem_wr   <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    gnt_q    <= win;
                    ptr      <= win[1];
                    owner    <= win[1];
                    mem_addr <= addr_sel;
                    wdata_q  <= wdata_sel;
                    mem_wr   <= we_sel;
                    mem_rd   <= !we_sel;
                    state    <= we_sel ? WRITE : READ;
                end
                WRITE: state <= IDLE;
                READ:  state <= CAPTURE;
                default: begin
                    mem_rd          <= 1'b0;
                    rdata_q[owner]  <= mem_data;
                    rvalid_q[owner] <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt_q[0]) gnt_cnt0 <= sat_inc(gnt_cnt0);
            if (gnt_q[1]) gnt_cnt1 <= sat_inc(gnt_cnt1);
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural 32x8 memory
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_wr, mem_rd;
    logic [4:0] mem_addr;
    wire  [7:0] mem_data;
    logic       probe_en = 1'b0;
    logic [7:0] mem [32];
    int         checks = 0;
    int         fails = 0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    mem_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
`ifdef MEM_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;
    // probe drives 8'hA5 only when the memory is silent; any DUT drive corrupts it
    assign mem_data = mem_rd ? mem[mem_addr] : (probe_en ? 8'hA5 : 'z);

    task automatic set_req(input int r, input logic v, input logic we, input logic [4:0] a, input logic [7:0] d);
        if (r == 0) begin
            bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic op(input int r, input logic we, input logic [4:0] a, input logic [7:0] d,
                      output int gc, output int vc, output logic [7:0] rd, output logic clash);
        gc = -1; vc = -1; rd = '0; clash = 1'b0;
        set_req(r, 1'b1, we, a, d);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            clash |= mem_wr & mem_rd;
            if (gc < 0 && (r == 0 ? bus.gnt0 : bus.gnt1)) begin
                gc = c;
                set_req(r, 1'b0, we, a, d);
            end
            if (r == 0 ? bus.rvalid0 : bus.rvalid1) begin
                vc = c;
                rd = (r == 0) ? bus.rdata0 : bus.rdata1;
            end
            if (we ? (gc >= 0 && c > gc) : (vc >= 0)) break;
        end
        set_req(r, 1'b0, we, a, d);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, mem_wr, mem_rd} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, mem_wr, mem_rd});
        end
        checks++;
        if (mem_addr !== 5'd0) begin fails++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        checks++;
        if ({bus.rdata0, bus.rdata1} !== 16'h0) begin
            fails++; $display("FAIL reset_rdata: got %h want 0000", {bus.rdata0, bus.rdata1});
        end
        probe_en = 1'b1; #1;
        checks++;
        if (mem_data !== 8'hA5) begin fails++; $display("FAIL reset_bus_release: got %h want a5", mem_data); end
        probe_en = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, mem_wr, mem_rd} !== 4'b0) begin
            fails++; $display("FAIL idle_no_req: got %b want 0000", {bus.gnt0, bus.gnt1, mem_wr, mem_rd});
        end
    endtask

    task automatic test_req0_rw();
        int gc, vc; logic [7:0] rd; logic cl;
        op(0, 1'b1, 5'd0, 8'hFF, gc, vc, rd, cl);
        checks++;
        if (gc !== 1) begin fails++; $display("FAIL w0_gnt_cycle: got %0d want 1", gc); end
        checks++;
        if (mem[0] !== 8'hFF) begin fails++; $display("FAIL w0_mem: got %h want ff", mem[0]); end
        op(0, 1'b0, 5'd0, 8'h5A, gc, vc, rd, cl);
        checks++;
        if (gc !== 1) begin fails++; $display("FAIL r0_gnt_cycle: got %0d want 1", gc); end
        checks++;
        if (vc !== 3) begin fails++; $display("FAIL r0_rvalid_cycle: got %0d want 3", vc); end
        checks++;
        if (rd !== 8'hFF) begin fails++; $display("FAIL r0_rdata: got %h want ff", rd); end
        @(posedge clk); #1;
        checks++;
        if (bus.rdata0 !== 8'hFF || bus.rvalid0 !== 1'b0) begin
            fails++; $display("FAIL r0_hold: got %h/%b want ff/0", bus.rdata0, bus.rvalid0);
        end
    endtask

    task automatic test_req1_rw();
        int gc, vc; logic [7:0] rd; logic cl;
        op(1, 1'b1, 5'h1F, 8'h00, gc, vc, rd, cl);
        checks++;
        if (gc !== 1 || mem[31] !== 8'h00) begin
            fails++; $display("FAIL w1: got gnt %0d mem %h want 1/00", gc, mem[31]);
        end
        op(1, 1'b0, 5'h1F, 8'h5A, gc, vc, rd, cl);
        checks++;
        if (vc !== 3 || rd !== 8'h00) begin
            fails++; $display("FAIL r1: got cycle %0d data %h want 3/00", vc, rd);
        end
        checks++;
        if (bus.rdata0 !== 8'hFF) begin fails++; $display("FAIL r1_rdata0_untouched: got %h want ff", bus.rdata0); end
    endtask

    task automatic test_alternate();
        int seq[8] = '{default: -1};
        int n = 0;
        logic both = 1'b0;
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 5'd8, 8'h10);
        set_req(1, 1'b1, 1'b1, 5'd9, 8'h20);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(posedge clk); #1;
            both |= bus.gnt0 & bus.gnt1;
            if (bus.gnt0 | bus.gnt1) begin
                seq[n] = bus.gnt1 ? 1 : 0;
                n++;
            end
        end
        set_req(0, 1'b0, 1'b1, 5'd8, 8'h10);
        set_req(1, 1'b0, 1'b1, 5'd9, 8'h20);
        @(posedge clk); #1;
        checks++;
        if (n !== 8) begin fails++; $display("FAIL alt_grant_count: got %0d want 8", n); end
        checks++;
        if (both !== 1'b0) begin fails++; $display("FAIL alt_double_grant: got %b want 0", both); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seq[i] !== i % 2) begin fails++; $display("FAIL alt_order[%0d]: got %0d want %0d", i, seq[i], i % 2); end
        end
    endtask

    task automatic test_fill();
        int gc, vc; logic [7:0] rd; logic cl;
        logic clash = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            op(i % 2, 1'b1, 5'(31 - i), 8'(i), gc, vc, rd, cl);
            clash |= cl;
        end
        for (int i = 0; i <= 30; i++) begin
            op((i + 1) % 2, 1'b0, 5'(31 - i), 8'h5A, gc, vc, rd, cl);
            clash |= cl;
            checks++;
            if (rd !== 8'(i)) begin fails++; $display("FAIL fill_rd[%0d]: got %h want %h", 31 - i, rd, 8'(i)); end
        end
        checks++;
        if (clash !== 1'b0) begin fails++; $display("FAIL fill_wr_rd_overlap: got %b want 0", clash); end
        probe_en = 1'b1; #1;
        checks++;
        if (mem_data !== 8'hA5) begin fails++; $display("FAIL idle_bus_release: got %h want a5", mem_data); end
        probe_en = 1'b0;
    endtask

    task automatic test_reset_capture();
        int gc, vc; logic [7:0] rd; logic cl;
        logic seen = 1'b0;
        set_req(0, 1'b1, 1'b0, 5'd26, 8'h5A);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 5'd26, 8'h5A);
        @(posedge clk); #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_data !== 8'd5) begin
            fails++; $display("FAIL cap_setup: got rd %b data %h want 1/05", mem_rd, mem_data);
        end
        rst = 1'b1; #1;
        checks++;
        if (mem_rd !== 1'b0 || bus.rvalid0 !== 1'b0) begin
            fails++; $display("FAIL cap_rst_ctrl: got rd %b rvalid %b want 0/0", mem_rd, bus.rvalid0);
        end
        probe_en = 1'b1; #1;
        checks++;
        if (mem_data !== 8'hA5) begin fails++; $display("FAIL cap_rst_bus: got %h want a5", mem_data); end
        probe_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            seen |= bus.rvalid0 | bus.rvalid1 | bus.gnt0 | bus.gnt1;
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL cap_rst_no_pulse: got %b want 0", seen); end
        checks++;
        if (bus.rdata0 !== 8'h00) begin fails++; $display("FAIL cap_rst_rdata0: got %h want 00", bus.rdata0); end
        op(0, 1'b0, 5'd26, 8'h5A, gc, vc, rd, cl);
        checks++;
        if (vc !== 3 || rd !== 8'd5) begin
            fails++; $display("FAIL cap_reread: got cycle %0d data %h want 3/05", vc, rd);
        end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        int gc, vc; logic [7:0] rd; logic cl;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
            fails++; $display("FAIL stats_reset: got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1);
        end
        for (int i = 0; i < 5; i++) op(0, 1'b1, 5'(i), 8'(i), gc, vc, rd, cl);
        for (int i = 0; i < 3; i++) op(1, 1'b0, 5'(i), 8'h00, gc, vc, rd, cl);
        @(posedge clk); #1;
        checks++;
        if (gnt_cnt0 !== 16'd5) begin fails++; $display("FAIL stats_cnt0: got %0d want 5", gnt_cnt0); end
        checks++;
        if (gnt_cnt1 !== 16'd3) begin fails++; $display("FAIL stats_cnt1: got %0d want 3", gnt_cnt1); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
        set_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
        test_reset();
        test_req0_rw();
        test_req1_rw();
        test_alternate();
        test_fill();
        test_reset_capture();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
